// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of a shared SPI bus between AMP, ADC and DAC slave engines.
// Sequences select setup, a GO pulse, a DONE wait with timeout, and a bus release gap.
module spi_bus_arbiter #(
    parameter int SETUP_CYC = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [1:0] select,
    output logic       GO_AMP,
    output logic       GO_ADC,
    output logic       GO_DAC,
    input  logic       DONE_AMP,
    input  logic       DONE_ADC,
    input  logic       DONE_DAC,
    output logic [2:0] ack,
    output logic [2:0] err,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_GO      = 3'd2;
    localparam logic [2:0] S_ARM     = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0] state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] select_q, select_d;
    logic [1:0] last_q, last_d;
    logic [3:0] setup_cnt_q, setup_cnt_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    logic [1:0] win_idx;
    logic       win_found;
    logic [1:0] idx;
    logic       done_sel;

    // Search starts one past the previous owner and wraps 0->1->2->0.
    always_comb begin
        win_idx   = 2'd0;
        win_found = 1'b0;
        idx       = last_q;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign done_sel = |(grant_q & {DONE_DAC, DONE_ADC, DONE_AMP});

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        select_d    = select_q;
        last_d      = last_q;
        setup_cnt_d = setup_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d     = 3'b001 << win_idx;
                    select_d    = win_idx + 2'd1;
                    setup_cnt_d = 4'(SETUP_CYC - 1);
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (setup_cnt_q == 4'd0) begin
                    state_d = S_GO;
                end else begin
                    setup_cnt_d = setup_cnt_q - 4'd1;
                end
            end
            S_GO: state_d = S_ARM;
            S_ARM: begin
                tmo_cnt_d = 8'(TIMEOUT);
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Bus is dropped on entry to RELEASE so select is already 0 there;
                // the owner index is captured here while select still holds it.
                if (done_sel || tmo_cnt_q == 8'd0) begin
                    last_d   = select_q - 2'd1;
                    grant_d  = 3'b000;
                    select_d = 2'd0;
                    state_d  = S_RELEASE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 8'd1;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default: begin
                grant_d  = 3'b000;
                select_d = 2'd0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= 3'b000;
            select_q    <= 2'd0;
            last_q      <= 2'd2;
            setup_cnt_q <= 4'd0;
            tmo_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            select_q    <= select_d;
            last_q      <= last_d;
            setup_cnt_q <= setup_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign select    = select_q;
    assign GO_AMP    = (state_q == S_GO) && grant_q[0];
    assign GO_ADC    = (state_q == S_GO) && grant_q[1];
    assign GO_DAC    = (state_q == S_GO) && grant_q[2];
    // DONE outranks a timeout expiring in the same WAIT cycle.
    assign ack       = (state_q == S_WAIT && done_sel) ? grant_q : 3'b000;
    assign err       = (state_q == S_WAIT && !done_sel && tmo_cnt_q == 8'd0) ? grant_q : 3'b000;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scenario bench for spi_bus_arbiter: a SETUP_CYC=1/TIMEOUT=4 instance with an ack/err
// scoreboard, and a SETUP_CYC=3/TIMEOUT=255 instance for setup latency and wrong-slave DONE.
module tb_spi_bus_arbiter;

    localparam logic [2:0] ST_ARM  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] req, grant, ack, err, dbg_state;
    logic [1:0] select;
    logic       GO_AMP, GO_ADC, GO_DAC, DONE_AMP, DONE_ADC, DONE_DAC, busy;
    logic [2:0] go_vec;

    logic [2:0] req2, grant2, ack2, err2, dbg_state2;
    logic [1:0] select2;
    logic       GO_AMP2, GO_ADC2, GO_DAC2, DONE_AMP2, DONE_ADC2, DONE_DAC2, busy2;

    int tests_run = 0;
    int fails     = 0;
    logic [5:0] exp_q[$];
    logic [5:0] exp_e;
    logic [1:0] exp_sel;

    assign go_vec = {GO_DAC, GO_ADC, GO_AMP};

    spi_bus_arbiter #(.SETUP_CYC(1), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .select(select),
        .GO_AMP(GO_AMP), .GO_ADC(GO_ADC), .GO_DAC(GO_DAC),
        .DONE_AMP(DONE_AMP), .DONE_ADC(DONE_ADC), .DONE_DAC(DONE_DAC),
        .ack(ack), .err(err), .busy(busy), .dbg_state(dbg_state)
    );

    spi_bus_arbiter #(.SETUP_CYC(3), .TIMEOUT(255)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .grant(grant2), .select(select2),
        .GO_AMP(GO_AMP2), .GO_ADC(GO_ADC2), .GO_DAC(GO_DAC2),
        .DONE_AMP(DONE_AMP2), .DONE_ADC(DONE_ADC2), .DONE_DAC(DONE_DAC2),
        .ack(ack2), .err(err2), .busy(busy2), .dbg_state(dbg_state2)
    );

    // Every cycle: bus invariants, and any ack/err pulse is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            case (grant)
                3'b001:  exp_sel = 2'd1;
                3'b010:  exp_sel = 2'd2;
                3'b100:  exp_sel = 2'd3;
                default: exp_sel = 2'd0;
            endcase
            tests_run++;
            if (!(grant == 3'b000 || $onehot(grant)) || select !== exp_sel ||
                $countones(go_vec) > 1 || (go_vec & ~grant) != 3'b000) begin
                fails++;
                $display("FAIL invariant: grant=%b select=%0d go=%b", grant, select, go_vec);
            end
            if ((ack | err) != 3'b000) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard: unexpected err/ack=%b/%b, none expected", err, ack);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({err, ack} !== exp_e) begin
                        fails++;
                        $display("FAIL scoreboard: err/ack=%b/%b expected %b/%b",
                                 err, ack, exp_e[5:3], exp_e[2:0]);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_done(input logic [2:0] v);
        DONE_AMP = v[0];
        DONE_ADC = v[1];
        DONE_DAC = v[2];
    endtask

    task automatic wait_go(output logic found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            next_cycle();
            sample();
            if (go_vec != 3'b000) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            fails++;
            $display("FAIL wait_go: no GO within 20 cycles, req=%b", req);
        end
    endtask

    task automatic test_reset();
        repeat (2) next_cycle();
        sample();
        tests_run++;
        if ({grant, select, go_vec, ack, err, busy, dbg_state} !== 17'd0) begin
            fails++;
            $display("FAIL reset: grant=%b select=%0d go=%b ack=%b err=%b busy=%b state=%0d expected all 0",
                     grant, select, go_vec, ack, err, busy, dbg_state);
        end
        tests_run++;
        if ({grant2, select2, GO_AMP2, GO_ADC2, GO_DAC2, ack2, err2, busy2} !== 14'd0) begin
            fails++;
            $display("FAIL reset2: grant=%b select=%0d busy=%b expected 0", grant2, select2, busy2);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_contention();
        logic [2:0] order[4];
        logic found;
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_go(found);
            tests_run++;
            if (go_vec !== order[k] || grant !== order[k]) begin
                fails++;
                $display("FAIL contention_order[%0d]: go=%b grant=%b expected %b", k, go_vec, grant, order[k]);
            end
            next_cycle();
            next_cycle();
            next_cycle();
            set_done(order[k]);
            exp_q.push_back({3'b000, order[k]});
            if (k == 3) req = 3'b000;
            sample();
            tests_run++;
            if (ack !== order[k]) begin
                fails++;
                $display("FAIL contention_ack[%0d]: ack=%b expected %b", k, ack, order[k]);
            end
            next_cycle();
            set_done(3'b000);
            sample();
            tests_run++;
            if (select !== 2'd0 || grant !== 3'b000) begin
                fails++;
                $display("FAIL contention_gap[%0d]: select=%0d grant=%b expected 0/000", k, select, grant);
            end
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_single();
        logic [1:0] es;
        next_cycle();
        req = 3'b001;
        exp_q.push_back(6'b000_001);
        sample();
        tests_run++;
        if (select !== 2'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_c0: select=%0d busy=%b expected 0/0", select, busy);
        end
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            if (c == 3) req = 3'b000;
            if (c == 5) set_done(3'b001);
            if (c == 6) set_done(3'b000);
            sample();
            es = (c >= 1 && c <= 5) ? 2'd1 : 2'd0;
            tests_run++;
            if (select !== es || GO_AMP !== (c == 2) || ack !== ((c == 5) ? 3'b001 : 3'b000) ||
                busy !== (c <= 6)) begin
                fails++;
                $display("FAIL single_c%0d: select=%0d go_amp=%b ack=%b busy=%b expected %0d/%b/%b/%b",
                         c, select, GO_AMP, ack, busy, es, (c == 2), (c == 5) ? 3'b001 : 3'b000, (c <= 6));
            end
        end
    endtask

    task automatic test_timeout();
        logic found;
        logic [2:0] ee;
        req = 3'b010;
        exp_q.push_back(6'b010_000);
        wait_go(found);
        tests_run++;
        if (go_vec !== 3'b010) begin
            fails++;
            $display("FAIL timeout_go: go=%b expected 010", go_vec);
        end
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            if (c == 2) req = 3'b000;
            sample();
            ee = (c == 6) ? 3'b010 : 3'b000;
            tests_run++;
            if (err !== ee || ack !== 3'b000 || (c == 1 && dbg_state !== ST_ARM) ||
                (c == 7 && select !== 2'd0)) begin
                fails++;
                $display("FAIL timeout_c%0d: err=%b ack=%b state=%0d select=%0d expected err=%b ack=000",
                         c, err, ack, dbg_state, select, ee);
            end
        end
        next_cycle();
        req = 3'b001;
        wait_go(found);
        tests_run++;
        if (go_vec !== 3'b001) begin
            fails++;
            $display("FAIL timeout_next_go: go=%b expected 001", go_vec);
        end
        next_cycle();
        req = 3'b000;
        next_cycle();
        set_done(3'b001);
        exp_q.push_back(6'b000_001);
        sample();
        tests_run++;
        if (ack !== 3'b001) begin
            fails++;
            $display("FAIL timeout_next_ack: ack=%b expected 001", ack);
        end
        next_cycle();
        set_done(3'b000);
    endtask

    task automatic test_reset_wait();
        logic found;
        next_cycle();
        req = 3'b010;
        wait_go(found);
        next_cycle();
        next_cycle();
        sample();
        tests_run++;
        if (dbg_state !== ST_WAIT || grant !== 3'b010) begin
            fails++;
            $display("FAIL rstwait_pre: state=%0d grant=%b expected %0d/010", dbg_state, grant, ST_WAIT);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        req = 3'b011;
        sample();
        tests_run++;
        if (select !== 2'd0 || grant !== 3'b000 || busy !== 1'b0 || ack !== 3'b000 || err !== 3'b000) begin
            fails++;
            $display("FAIL rstwait_post: select=%0d grant=%b busy=%b ack=%b err=%b expected all 0",
                     select, grant, busy, ack, err);
        end
        wait_go(found);
        tests_run++;
        if (go_vec !== 3'b001) begin
            fails++;
            $display("FAIL rstwait_rr: go=%b expected 001", go_vec);
        end
        next_cycle();
        req = 3'b000;
        next_cycle();
        set_done(3'b001);
        exp_q.push_back(6'b000_001);
        next_cycle();
        set_done(3'b000);
    endtask

    task automatic test_done_vs_timeout();
        logic found;
        req = 3'b100;
        wait_go(found);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 2) req = 3'b000;
            if (c == 6) begin
                set_done(3'b100);
                exp_q.push_back(6'b000_100);
            end
            sample();
        end
        tests_run++;
        if (ack !== 3'b100 || err !== 3'b000) begin
            fails++;
            $display("FAIL done_vs_timeout: ack=%b err=%b expected 100/000", ack, err);
        end
        next_cycle();
        set_done(3'b000);
        sample();
        tests_run++;
        if (select !== 2'd0) begin
            fails++;
            $display("FAIL done_vs_timeout_rel: select=%0d expected 0", select);
        end
    endtask

    task automatic test_stale_done();
        logic found;
        next_cycle();
        set_done(3'b010);
        req = 3'b010;
        exp_q.push_back(6'b000_010);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            next_cycle();
            sample();
            if (go_vec != 3'b000) found = 1'b1;
            tests_run++;
            if (ack !== 3'b000) begin
                fails++;
                $display("FAIL stale_pre_go: ack=%b expected 000", ack);
            end
        end
        tests_run++;
        if (!found || go_vec !== 3'b010) begin
            fails++;
            $display("FAIL stale_go: go=%b expected 010", go_vec);
        end
        next_cycle();
        req = 3'b000;
        sample();
        tests_run++;
        if (ack !== 3'b000 || dbg_state !== ST_ARM) begin
            fails++;
            $display("FAIL stale_arm: ack=%b state=%0d expected 000/%0d", ack, dbg_state, ST_ARM);
        end
        next_cycle();
        sample();
        tests_run++;
        if (ack !== 3'b010) begin
            fails++;
            $display("FAIL stale_wait: ack=%b expected 010", ack);
        end
        next_cycle();
        set_done(3'b000);
        repeat (2) next_cycle();
    endtask

    task automatic test_wrong_slave();
        logic [1:0] es;
        logic [2:0] ea;
        next_cycle();
        req2 = 3'b010;
        sample();
        tests_run++;
        if (select2 !== 2'd0) begin
            fails++;
            $display("FAIL wrong_c0: select=%0d expected 0", select2);
        end
        for (int c = 1; c <= 34; c++) begin
            next_cycle();
            if (c == 5)  req2 = 3'b000;
            DONE_AMP2 = (c == 7);
            DONE_DAC2 = (c == 9 || c == 10);
            DONE_ADC2 = (c == 31);
            sample();
            es = (c <= 31) ? 2'd2 : 2'd0;
            ea = (c == 31) ? 3'b010 : 3'b000;
            tests_run++;
            if (select2 !== es || GO_ADC2 !== (c == 4) || GO_AMP2 !== 1'b0 || GO_DAC2 !== 1'b0 ||
                ack2 !== ea || err2 !== 3'b000 || busy2 !== (c <= 32) ||
                (c >= 6 && c <= 31 && dbg_state2 !== ST_WAIT)) begin
                fails++;
                $display("FAIL wrong_c%0d: select=%0d go=%b%b%b ack=%b err=%b busy=%b state=%0d expected select=%0d ack=%b",
                         c, select2, GO_DAC2, GO_ADC2, GO_AMP2, ack2, err2, busy2, dbg_state2, es, ea);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;
        req2 = 3'b000;
        set_done(3'b000);
        DONE_AMP2 = 1'b0;
        DONE_ADC2 = 1'b0;
        DONE_DAC2 = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_reset_wait();
        test_done_vs_timeout();
        test_stale_done();
        test_wrong_slave();
        repeat (3) next_cycle();
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected pulses never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles that select is held stable before GO is pulsed (legal 1..15).
REQ-002 Parameter TIMEOUT, default 255: maximum cycles spent waiting for a DONE before abort (legal 2..255).
REQ-003 clk  input  1  system clock; all logic updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  3  level requests: bit0 = AMP gain write, bit1 = ADC conversion, bit2 = DAC write.
REQ-006 grant  output  3  one-hot owner of the shared SPI bus; 0 when idle.
REQ-007 select  output  2  SPI mux select: 0 idle, 1 AMP, 2 ADC, 3 DAC.
REQ-008 GO_AMP, GO_ADC, GO_DAC  output  1 each  one-cycle start pulse to the addressed SPI slave engine.
REQ-009 DONE_AMP, DONE_ADC, DONE_DAC  input  1 each  completion level or pulse from the slave engine.
REQ-010 ack  output  3  one-cycle pulse on the bit of the requester whose transfer completed normally.
REQ-011 err  output  3  one-cycle pulse on the bit of the requester whose transfer timed out.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, SETUP, GO, ARM, WAIT, RELEASE.
REQ-014 IDLE: when req != 0, pick the winner by round-robin, set grant and select, load the setup counter with SETUP_CYC-1, and go to SETUP on the next edge.
REQ-015 Round-robin: the search starts at the bit after the last granted one (order 0->1->2->0); after reset, bit0 has priority.
REQ-016 SETUP: hold select; decrement the counter each cycle; go to GO when the counter is 0 (SETUP_CYC cycles in total).
REQ-017 GO: assert exactly one GO_x for one cycle, matching grant; go to ARM.
REQ-018 ARM: one dead cycle in which DONE is ignored (covers a slave engine whose DONE is still high from the prior transfer); load the timeout counter with TIMEOUT; go to WAIT.
REQ-019 WAIT: sample only the DONE of the granted slave.
  - If it is high: pulse ack for the granted bit and go to RELEASE.
  - Otherwise: decrement the timeout counter; at 0, pulse err for the granted bit and go to RELEASE.
REQ-020 When DONE and timeout expiry happen in the same cycle, DONE wins: ack is pulsed and err is not.
REQ-021 RELEASE: drive select to 0 and grant to 0, record the last-granted index, and go to IDLE; there is at least one cycle with select = 0 between owners.
REQ-022 Dropping req mid-transfer SHALL NOT abort the transfer; the current owner runs to ack or err.
REQ-023 DONE inputs of non-granted slaves SHALL be ignored in every state.
REQ-024 grant SHALL always be one-hot or zero, and select SHALL always be consistent with grant.
REQ-025 Minimum latency, req rising to GO: 1 + SETUP_CYC cycles.
REQ-026 Minimum occupancy per transfer: SETUP_CYC + 4 cycles with an immediate DONE.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL:
  - enter IDLE;
  - clear grant, select, every GO_x, ack, err, busy and both counters;
  - set last-granted to 2, so that bit0 wins first.
REQ-028 Reset mid-transfer SHALL abort with no ack or err pulse, and select SHALL be 0 on the cycle after the reset edge.

Verification
REQ-029 Single request, SETUP_CYC=1: req=001 at cycle 0, DONE_AMP high at cycle 5 -> select=1 at cycles 1-5; GO_AMP at cycle 2; ack=001 at cycle 5; select=0 at cycle 6; busy low at cycle 7.
REQ-030 Contention: req=111 held continuously, each DONE returned 3 cycles after its GO -> grant order 001, 010, 100, 001; no GO overlap; select=0 for at least 1 cycle between owners.
REQ-031 Timeout, TIMEOUT=4: req=010 with DONE_ADC held low -> err=010 exactly 5 cycles after the ARM cycle; no ack; the bus is released; a following req=001 is served.
REQ-032 Stale DONE: DONE_ADC held high throughout, req=010 -> DONE is ignored in GO and ARM; ack occurs on the first WAIT cycle, never before GO.
REQ-033 Reset in WAIT: assert rst for 1 cycle while ADC is granted -> next cycle select=0, grant=0, busy=0, with no ack or err; afterwards req=011 grants AMP first.
REQ-034 Wrong-slave DONE: ADC granted, DONE_AMP pulsed -> no ack and no state change; with TIMEOUT=255, ack=010 follows only when DONE_ADC is raised.
